// File: rtl/symbol_price_tracker.sv
// Per-symbol last/high/low price table fed by a market-data parser.
// Two-stage pipeline: register the input, then look up the symbol, update the slot and emit the update.
module symbol_price_tracker #(
    parameter int NUM_SLOTS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] symbol,
    input  logic [15:0] price,
    input  logic        in_valid,
    input  logic        clear,
    output logic        upd_valid,
    output logic [3:0]  upd_slot,
    output logic [15:0] upd_symbol,
    output logic [15:0] upd_price,
    output logic [16:0] upd_delta,
    output logic        upd_new,
    output logic [15:0] upd_high,
    output logic [15:0] upd_low,
    output logic        table_full,
    output logic [15:0] drop_count
);

    logic                 s1_valid;
    logic [15:0]          s1_symbol;
    logic [15:0]          s1_price;

    logic [NUM_SLOTS-1:0] alloc;
    logic [15:0]          slot_symbol [NUM_SLOTS];
    logic [15:0]          slot_last   [NUM_SLOTS];
    logic [15:0]          slot_high   [NUM_SLOTS];
    logic [15:0]          slot_low    [NUM_SLOTS];

    logic                 hit;
    logic [3:0]           hit_idx;
    logic                 free_found;
    logic [3:0]           free_idx;
    logic [15:0]          sel_last;
    logic [15:0]          sel_high;
    logic [15:0]          sel_low;

    logic                 accept;
    logic                 drop;
    logic [3:0]           wr_idx;
    logic [15:0]          new_high;
    logic [15:0]          new_low;
    logic [16:0]          new_delta;

    // Descending scan so the last assignment wins: lowest-index hit and lowest-index free slot.
    // NOTE: every variable gets a default first, otherwise the partial assignments below infer latches.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel_last   = '0;
        sel_high   = '0;
        sel_low    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (alloc[i] && slot_symbol[i] == s1_symbol) begin
                hit      = 1'b1;
                hit_idx  = 4'(i);
                sel_last = slot_last[i];
                sel_high = slot_high[i];
                sel_low  = slot_low[i];
            end
            if (!alloc[i]) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
    end

    assign accept     = s1_valid && (hit || free_found);
    assign drop       = s1_valid && !hit && !free_found;
    assign wr_idx     = hit ? hit_idx : free_idx;
    assign new_high   = (hit && sel_high > s1_price) ? sel_high : s1_price;
    assign new_low    = (hit && sel_low < s1_price) ? sel_low : s1_price;
    assign new_delta  = hit ? ({1'b0, s1_price} - {1'b0, sel_last}) : '0;
    assign table_full = &alloc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_symbol  <= '0;
            s1_price   <= '0;
            alloc      <= '0;
            drop_count <= '0;
            upd_valid  <= 1'b0;
            upd_slot   <= '0;
            upd_symbol <= '0;
            upd_price  <= '0;
            upd_delta  <= '0;
            upd_new    <= 1'b0;
            upd_high   <= '0;
            upd_low    <= '0;
        end else if (clear) begin
            // Whatever sits in stage 1 and whatever arrives this cycle are both discarded.
            s1_valid   <= 1'b0;
            alloc      <= '0;
            drop_count <= '0;
            upd_valid  <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_symbol <= symbol;
            s1_price  <= price;
            upd_valid <= accept;
            if (accept) begin
                upd_slot   <= wr_idx;
                upd_symbol <= s1_symbol;
                upd_price  <= s1_price;
                upd_delta  <= new_delta;
                upd_new    <= !hit;
                upd_high   <= new_high;
                upd_low    <= new_low;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!hit && wr_idx == 4'(i)) alloc[i] <= 1'b1;
                end
            end
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // NOTE: slot contents are left unreset on purpose; a slot is only read once its alloc bit is set,
    // and the alloc bits are what reset and clear act on.
    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_idx == 4'(i)) begin
                    slot_symbol[i] <= s1_symbol;
                    slot_last[i]   <= s1_price;
                    slot_high[i]   <= new_high;
                    slot_low[i]    <= new_low;
                end
            end
        end
    end

endmodule

// File: doc/symbol_price_tracker.md
SYMBOL_PRICE_TRACKER -- requirements
Module: symbol_price_tracker

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of symbol table entries (2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port symbol  input  16  symbol from upstream market_data_parser.
REQ-005 SHALL have port price  input  16  unsigned price from upstream parser.
REQ-006 SHALL have port in_valid  input  1  symbol/price valid this cycle (parser output_valid).
REQ-007 SHALL have port clear  input  1  synchronous table/statistics clear.
REQ-008 SHALL have port upd_valid  output  1  one-cycle pulse, update fields valid.
REQ-009 SHALL have port upd_slot  output  4  table slot index of the update.
REQ-010 SHALL have port upd_symbol  output  16  symbol of the update.
REQ-011 SHALL have port upd_price  output  16  new last price.
REQ-012 SHALL have port upd_delta  output  17  signed, new price minus previous last price.
REQ-013 SHALL have port upd_new  output  1  symbol allocated by this update.
REQ-014 SHALL have port upd_high  output  16  session high for symbol after update.
REQ-015 SHALL have port upd_low  output  16  session low for symbol after update.
REQ-016 SHALL have port table_full  output  1  all NUM_SLOTS slots allocated.
REQ-017 SHALL have port drop_count  output  16  updates dropped for lack of a free slot.

Function
REQ-018 SHALL register symbol/price/in_valid into stage 1 every cycle; no backpressure, every valid cycle accepted.
REQ-019 SHALL in stage 2 compare the stage-1 symbol against all allocated slots in parallel and update table and outputs at the next edge; latency in_valid edge -> upd_valid = 2 cycles.
REQ-020 SHALL per slot hold: alloc bit, symbol, last, high, low.
REQ-021 SHALL on hit: upd_delta = price - last (17-bit signed), last = price, high = max(high, price), low = min(low, price), upd_new = 0.
REQ-022 SHALL on miss with free slot: allocate lowest-index free slot, last = high = low = price, upd_delta = 0, upd_new = 1.
REQ-023 SHALL on miss with table full: change no slot, keep upd_valid = 0, increment drop_count, saturating at 0xFFFF.
REQ-024 SHALL treat each valid cycle as a distinct update; a repeated identical word gives delta 0 and upd_valid again.
REQ-025 SHALL resolve back-to-back updates to one symbol against state already updated by the previous one; no stale reads.
REQ-026 SHALL drive upd_valid high exactly one cycle per accepted update; other upd_* fields hold their last values otherwise.
REQ-027 SHALL on clear = 1: at the next edge free all slots, zero drop_count, deassert upd_valid, discard stage 1 contents; an in_valid in the same cycle is dropped and not counted.
REQ-028 SHALL derive table_full combinationally from alloc bits.

Reset
REQ-029 SHALL on reset = 0 immediately clear all alloc bits, stage 1, drop_count, upd_valid and all upd_* outputs to 0; table_full = 0.
REQ-030 SHALL discard an update in flight at reset; after release, first valid input gets slot 0 and upd_new = 1.

Verification
REQ-031 SHALL test: 0x4142/0x4344 after reset -> 2 cycles later upd_valid pulse, slot 0, upd_new 1, delta 0, high = low = 0x4344.
REQ-032 SHALL test: then 0x4142/0x4350 then 0x4142/0x4300 back-to-back -> deltas +0x000C then -0x0050, high 0x4350, low 0x4300, slot 0.
REQ-033 SHALL test: 4 distinct symbols then 0x5854/0x8940 -> slots 0..3, table_full 1, fifth has no upd_valid, drop_count = 1.
REQ-034 SHALL test: in_valid held 2 cycles with 0x5847/0x5955 -> two pulses, second delta 0, upd_new 0.
REQ-035 SHALL test: reset pulled low the cycle after an in_valid -> no upd_valid, all outputs 0, next input lands in slot 0.
REQ-036 SHALL test: clear asserted with in_valid on a full table -> table empty, drop_count 0, no pulse, next symbol slot 0.
